alu_pipe_unit: RTL and testbench

//  Pipelined integer execution unit between reservation station and ROB/CDB of the Tomasulo RV32 core.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/alu_mul_iter.sv | 77 +++++++
 rtl/alu_pipe_unit.sv | 209 ++++++++++++++++++++
 tb/tb_alu_pipe_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, immediate-format classifier and mul FSM states
// Shared by the decoder, the reservation station and alu_pipe_unit.
//   OP_*          6-bit internal opcodes
//   imm_fmt()     which immediate extension an opcode uses
//   is_mul_op()   true for the RV32M multiply group
//   mul_state_e   iterative multiplier sequencing states
package alu_pkg;

  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SUB    = 6'd1;
  localparam logic [5:0] OP_SLL    = 6'd2;
  localparam logic [5:0] OP_SLT    = 6'd3;
  localparam logic [5:0] OP_SLTU   = 6'd4;
  localparam logic [5:0] OP_XOR    = 6'd5;
  localparam logic [5:0] OP_SRL    = 6'd6;
  localparam logic [5:0] OP_SRA    = 6'd7;
  localparam logic [5:0] OP_OR     = 6'd8;
  localparam logic [5:0] OP_AND    = 6'd9;
  localparam logic [5:0] OP_ADDI   = 6'd10;
  localparam logic [5:0] OP_SLTI   = 6'd11;
  localparam logic [5:0] OP_SLTIU  = 6'd12;
  localparam logic [5:0] OP_XORI   = 6'd13;
  localparam logic [5:0] OP_ORI    = 6'd14;
  localparam logic [5:0] OP_ANDI   = 6'd15;
  localparam logic [5:0] OP_SLLI   = 6'd16;
  localparam logic [5:0] OP_SRLI   = 6'd17;
  localparam logic [5:0] OP_SRAI   = 6'd18;
  localparam logic [5:0] OP_LUI    = 6'd19;
  localparam logic [5:0] OP_AUIPC  = 6'd20;
  localparam logic [5:0] OP_JAL    = 6'd21;
  localparam logic [5:0] OP_JALR   = 6'd22;
  localparam logic [5:0] OP_BEQ    = 6'd23;
  localparam logic [5:0] OP_BNE    = 6'd24;
  localparam logic [5:0] OP_BLT    = 6'd25;
  localparam logic [5:0] OP_BGE    = 6'd26;
  localparam logic [5:0] OP_BLTU   = 6'd27;
  localparam logic [5:0] OP_BGEU   = 6'd28;
  localparam logic [5:0] OP_MUL    = 6'd29;
  localparam logic [5:0] OP_MULH   = 6'd30;
  localparam logic [5:0] OP_MULHSU = 6'd31;
  localparam logic [5:0] OP_MULHU  = 6'd32;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_B, FMT_J, FMT_U} imm_fmt_e;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;

  function automatic imm_fmt_e imm_fmt(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI, OP_JALR:                  return FMT_I;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:    return FMT_B;
      OP_JAL:                                              return FMT_J;
      OP_LUI, OP_AUIPC:                                    return FMT_U;
      default:                                             return FMT_R;
    endcase
  endfunction

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative signed/unsigned shift-add multiplier
// Ports: clk, rst (async, active-high); start loads operands, abort cancels;
//   a, b with a_signed/b_signed; done is high during the final iteration cycle;
//   product (2*XLEN) is valid once done has been seen and until the next start.
// Operates on magnitudes and fixes the sign at the output, so one datapath
// serves MUL, MULH, MULHSU and MULHU.
module alu_mul_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              a_signed,
  input  logic              b_signed,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  localparam int CHUNK = (XLEN + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam int CNT_W = $clog2(MUL_CYCLES);

  logic              running;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_next, mcand;
  logic [XLEN-1:0]   mplier;
  logic              neg;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_neg = a_signed & a[XLEN-1];
  assign b_neg = b_signed & b[XLEN-1];
  assign a_mag = a_neg ? ('0 - a) : a;
  assign b_mag = b_neg ? ('0 - b) : b;

  // CHUNK multiplier bits consumed per cycle
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < CHUNK; i++) begin
      if (mplier[i]) acc_next = acc_next + (mcand << i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CNT_W'(MUL_CYCLES - 1);
      acc     <= '0;
      mcand   <= {{XLEN{1'b0}}, a_mag};
      mplier  <= b_mag;
      neg     <= a_neg ^ b_neg;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << CHUNK;
      mplier <= mplier >> CHUNK;
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  assign done    = running & (cnt == '0);
  assign product = neg ? ('0 - acc) : acc;

endmodule

// File: rtl/alu_pipe_unit.sv
// rtl/alu_pipe_unit.sv - pipelined RV32 integer execution unit (RS -> ROB/CDB)
// Optional build macro: ALU_MUL_EN (hosts alu_mul_iter for MUL/MULH/MULHSU/MULHU).
// Ports: clk, rst (async, active-high), flush (kill in-flight work);
//   in_valid/in_ready/in_op/in_v1/in_v2/in_imm/in_pc/in_tag from the RS;
//   out_valid/out_ready/out_data/out_jpc/out_taken/out_tag to the ROB.
// Non-mul ops complete in one cycle into a result register that holds until taken.
module alu_pipe_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 4,
  parameter int OP_W       = 6,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_v1,
  input  logic [XLEN-1:0]  in_v2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [XLEN-1:0]  out_jpc,
  output logic             out_taken,
  output logic [TAG_W-1:0] out_tag
);

  if (MUL_CYCLES < 2) begin : g_cfg_check
    $error("MUL_CYCLES must be at least 2");
  end

  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm_x, opb, sum, pc4, pc_rel;
  logic [4:0]      shamt;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] c_data, c_jpc;
  logic            c_taken;
  logic            imm_unused;

  logic             accept, is_mul, busy_mul, load_alu, load_mul;
  logic [XLEN-1:0]  mul_result, mul_pc4;
  logic [TAG_W-1:0] mul_tag;

  assign fmt        = imm_fmt(in_op);
  assign imm_unused = ^in_imm[XLEN-1:21];

  always_comb begin
    imm_x = '0;
    case (fmt)
      FMT_I:   imm_x = {{(XLEN-12){in_imm[11]}}, in_imm[11:0]};
      FMT_B:   imm_x = {{(XLEN-13){in_imm[12]}}, in_imm[12:0]};
      FMT_J:   imm_x = {{(XLEN-21){in_imm[20]}}, in_imm[20:0]};
      FMT_U:   imm_x = {in_imm[XLEN-13:0], 12'b0};
      default: imm_x = '0;
    endcase
  end

  // Register and immediate forms share one operand path; branches compare v1 with v2.
  assign opb    = (fmt == FMT_I) ? imm_x : in_v2;
  assign sum    = in_v1 + opb;
  assign shamt  = opb[4:0];
  assign lt_s   = $signed(in_v1) < $signed(opb);
  assign lt_u   = in_v1 < opb;
  assign eq     = in_v1 == opb;
  assign pc4    = in_pc + XLEN'(4);
  assign pc_rel = in_pc + imm_x;

  always_comb begin
    c_data  = '0;
    c_jpc   = pc4;
    c_taken = 1'b0;
    case (in_op)
      OP_ADD, OP_ADDI:   c_data = sum;
      OP_SUB:            c_data = in_v1 - opb;
      OP_SLL, OP_SLLI:   c_data = in_v1 << shamt;
      OP_SLT, OP_SLTI:   c_data = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU, OP_SLTIU: c_data = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR, OP_XORI:   c_data = in_v1 ^ opb;
      OP_SRL, OP_SRLI:   c_data = in_v1 >> shamt;
      OP_SRA, OP_SRAI:   c_data = $signed(in_v1) >>> shamt;
      OP_OR, OP_ORI:     c_data = in_v1 | opb;
      OP_AND, OP_ANDI:   c_data = in_v1 & opb;
      OP_LUI:            c_data = imm_x;
      OP_AUIPC:          c_data = pc_rel;
      OP_JAL: begin
        c_data  = pc4;
        c_jpc   = pc_rel;
        c_taken = 1'b1;
      end
      OP_JALR: begin
        c_data  = pc4;
        c_jpc   = {sum[XLEN-1:1], 1'b0};
        c_taken = 1'b1;
      end
      OP_BEQ:  c_taken = eq;
      OP_BNE:  c_taken = ~eq;
      OP_BLT:  c_taken = lt_s;
      OP_BGE:  c_taken = ~lt_s;
      OP_BLTU: c_taken = lt_u;
      OP_BGEU: c_taken = ~lt_u;
      default: c_data = '0;
    endcase
    if (fmt == FMT_B && c_taken) c_jpc = pc_rel;
  end

  assign in_ready = ~busy_mul & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign load_alu = accept & ~is_mul;

`ifdef ALU_MUL_EN
  mul_state_e       state_q, state_d;
  logic [TAG_W-1:0] pend_tag;
  logic [XLEN-1:0]  pend_pc;
  logic             pend_hi;
  logic             mul_start, mul_done;
  logic [2*XLEN-1:0] product;

  assign is_mul    = is_mul_op(in_op);
  assign mul_start = accept & is_mul;
  assign busy_mul  = state_q != MUL_IDLE;
  assign load_mul  = (state_q == MUL_DONE) & (~out_valid | out_ready) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MUL_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (mul_start) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_done)  state_d = MUL_DONE;
      MUL_DONE: if (load_mul)  state_d = MUL_IDLE;
      default:                 state_d = MUL_IDLE;
    endcase
    if (flush) state_d = MUL_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_tag <= '0;
      pend_pc  <= '0;
      pend_hi  <= 1'b0;
    end else if (mul_start) begin
      pend_tag <= in_tag;
      pend_pc  <= in_pc;
      pend_hi  <= in_op != OP_MUL;
    end
  end

  alu_mul_iter #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (mul_start),
    .abort    (flush),
    .a        (in_v1),
    .b        (in_v2),
    .a_signed ((in_op == OP_MULH) | (in_op == OP_MULHSU)),
    .b_signed (in_op == OP_MULH),
    .done     (mul_done),
    .product  (product)
  );

  assign mul_result = pend_hi ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
  assign mul_pc4    = pend_pc + XLEN'(4);
  assign mul_tag    = pend_tag;
`else
  assign is_mul     = 1'b0;
  assign busy_mul   = 1'b0;
  assign load_mul   = 1'b0;
  assign mul_result = '0;
  assign mul_pc4    = '0;
  assign mul_tag    = '0;
`endif

  // flush has priority over everything, including a same-cycle ROB take
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_jpc   <= '0;
      out_taken <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      out_data  <= c_data;
      out_jpc   <= c_jpc;
      out_taken <= c_taken;
      out_tag   <= in_tag;
    end else if (load_mul) begin
      out_valid <= 1'b1;
      out_data  <= mul_result;
      out_jpc   <= mul_pc4;
      out_taken <= 1'b0;
      out_tag   <= mul_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe_unit.sv
// tb/tb_alu_pipe_unit.sv - self-checking bench for alu_pipe_unit
module tb_alu_pipe_unit;
  import alu_pkg::*;

  localparam int XLEN = 32, TAG_W = 4, OP_W = 6, MUL_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_taken;
  logic [5:0]  in_op;
  logic [31:0] in_v1, in_v2, in_imm, in_pc, out_data, out_jpc;
  logic [3:0]  in_tag, out_tag;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit rnd_on     = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] jpc;
    logic        taken;
    logic [3:0]  tag;
    bit          is_mul;
    int          cyc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_pipe_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_v1(in_v1), .in_v2(in_v2), .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_jpc(out_jpc), .out_taken(out_taken), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: architectural result of one RV32 op, written from the ISA rules.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] v1, v2, imm, pc,
                                 input logic [3:0] tag);
    exp_t r;
    int sv1, sv2, si, sb, sj;
    int unsigned uv1, uv2;
    logic [31:0] u;
    longint p;
    longint unsigned pu;
    bit is_br;
    sv1 = v1; sv2 = v2; uv1 = v1; uv2 = v2;
    si = int'(imm << 20) >>> 20;
    sb = int'(imm << 19) >>> 19;
    sj = int'(imm << 11) >>> 11;
    u  = imm << 12;
    r.data = 0; r.jpc = pc + 4; r.taken = 0; r.tag = tag; r.is_mul = 0; r.cyc = 0;
    is_br = 0; p = 0; pu = 0;
    case (op)
      OP_ADD:   r.data = v1 + v2;
      OP_SUB:   r.data = v1 - v2;
      OP_SLL:   r.data = v1 << v2[4:0];
      OP_SLT:   r.data = (sv1 < sv2) ? 1 : 0;
      OP_SLTU:  r.data = (uv1 < uv2) ? 1 : 0;
      OP_XOR:   r.data = v1 ^ v2;
      OP_SRL:   r.data = v1 >> v2[4:0];
      OP_SRA:   r.data = sv1 >>> v2[4:0];
      OP_OR:    r.data = v1 | v2;
      OP_AND:   r.data = v1 & v2;
      OP_ADDI:  r.data = v1 + si;
      OP_SLTI:  r.data = (sv1 < si) ? 1 : 0;
      OP_SLTIU: r.data = (uv1 < int'(unsigned'(si))) ? 1 : 0;
      OP_XORI:  r.data = v1 ^ si;
      OP_ORI:   r.data = v1 | si;
      OP_ANDI:  r.data = v1 & si;
      OP_SLLI:  r.data = v1 << imm[4:0];
      OP_SRLI:  r.data = v1 >> imm[4:0];
      OP_SRAI:  r.data = sv1 >>> imm[4:0];
      OP_LUI:   r.data = u;
      OP_AUIPC: r.data = pc + u;
      OP_JAL:   begin r.data = pc + 4; r.jpc = pc + sj; r.taken = 1; end
      OP_JALR:  begin r.data = pc + 4; r.jpc = (v1 + si) & 32'hFFFF_FFFE; r.taken = 1; end
      OP_BEQ:   begin is_br = 1; r.taken = (v1 == v2); end
      OP_BNE:   begin is_br = 1; r.taken = (v1 != v2); end
      OP_BLT:   begin is_br = 1; r.taken = (sv1 < sv2); end
      OP_BGE:   begin is_br = 1; r.taken = (sv1 >= sv2); end
      OP_BLTU:  begin is_br = 1; r.taken = (uv1 < uv2); end
      OP_BGEU:  begin is_br = 1; r.taken = (uv1 >= uv2); end
`ifdef ALU_MUL_EN
      OP_MUL:    begin r.is_mul = 1; r.data = v1 * v2; end
      OP_MULH:   begin r.is_mul = 1; p = longint'(sv1) * longint'(sv2); r.data = 32'(p >>> 32); end
      OP_MULHSU: begin r.is_mul = 1; p = longint'(sv1) * longint'(uv2); r.data = 32'(p >>> 32); end
      OP_MULHU:  begin r.is_mul = 1; pu = longint'(uv1) * longint'(uv2); r.data = 32'(pu >> 32); end
`endif
      default:  r.data = 0;
    endcase
    if (is_br && r.taken) r.jpc = pc + sb;
    return r;
  endfunction

  // Per-cycle compare against the queue of accepted ops
  initial begin
    forever begin
      bit   exp_v, mul_busy;
      exp_t e;
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        continue;
      end
      exp_v = (q.size() > 0) && (cyc >= q[0].cyc + (q[0].is_mul ? MUL_CYCLES + 1 : 1));
      chk1("out_valid", out_valid, exp_v);
      if (out_valid && q.size() > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_jpc", out_jpc, q[0].jpc);
        chk1("out_taken", out_taken, q[0].taken);
        chk("out_tag", 32'(out_tag), 32'(q[0].tag));
      end
      mul_busy = (q.size() > 0) && q[0].is_mul && !out_valid;
      chk1("in_ready", in_ready, !mul_busy && (!out_valid || out_ready));
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) begin
          e = model(in_op, in_v1, in_v2, in_imm, in_pc, in_tag);
          e.cyc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_on) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] v1, v2, imm, pc,
                       input logic [3:0] tag);
    bit acc;
    acc = 0;
    in_op = op; in_v1 = v1; in_v2 = v2; in_imm = imm; in_pc = pc; in_tag = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      step();
    end
    in_valid = 1'b0;
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL issue_timeout: op %0d not accepted within 100 cycles", op);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_v1 = '0; in_v2 = '0; in_imm = '0; in_pc = '0; in_tag = '0;
    #1 rst = 1'b1;
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_jpc", out_jpc, 32'h0);
    chk1("rst_out_taken", out_taken, 1'b0);
    chk("rst_out_tag", 32'(out_tag), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // model pins against hand-computed values
    m = model(OP_ADDI, 32'd5, 32'd0, 32'hFFF, 32'h0, 4'h0);
    chk("model_addi", m.data, 32'd4);
    m = model(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h100, 4'h0);
    chk("model_blt_jpc", m.jpc, 32'h110);
    m = model(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h100, 4'h0);
    chk("model_bltu_jpc", m.jpc, 32'h104);
    m = model(OP_AUIPC, 32'd0, 32'd0, 32'd1, 32'h1000, 4'h0);
    chk("model_auipc", m.data, 32'h2000);

    // ADDI with negative immediate, tag echoed
    issue(OP_ADDI, 32'd5, 32'd0, 32'hFFF, 32'h0, 4'h3);
    @(negedge clk);
    chk1("addi_valid", out_valid, 1'b1);
    chk("addi_data", out_data, 32'd4);
    chk("addi_tag", 32'(out_tag), 32'd3);
    step();

    // signed vs unsigned branch
    issue(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h100, 4'h1);
    @(negedge clk);
    chk1("blt_taken", out_taken, 1'b1);
    chk("blt_jpc", out_jpc, 32'h110);
    step();
    issue(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h100, 4'h2);
    @(negedge clk);
    chk1("bltu_taken", out_taken, 1'b0);
    chk("bltu_jpc", out_jpc, 32'h104);
    step();

    // backpressure: second op must wait, first result held
    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'h200, 4'h4);
    in_op = OP_SUB; in_v1 = 32'd9; in_v2 = 32'd4; in_pc = 32'h204; in_tag = 4'h5;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("stall_in_ready", in_ready, 1'b0);
      chk("stall_hold_data", out_data, 32'd3);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_first", out_data, 32'd3);
    chk1("drain_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_second", out_data, 32'd5);
    step();

    // flush kills the held result and the presented op
    out_ready = 1'b0;
    issue(OP_ADD, 32'd7, 32'd8, 32'd0, 32'h300, 4'h6);
    in_op = OP_XOR; in_v1 = 32'hAA; in_v2 = 32'h55; in_tag = 4'h7;
    in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk1("flush_valid", out_valid, 1'b0);
    step();
    issue(OP_OR, 32'hF0, 32'h0F, 32'd0, 32'h308, 4'h8);
    @(negedge clk);
    chk("post_flush_or", out_data, 32'hFF);
    step();

`ifdef ALU_MUL_EN
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h400, 4'h9);
    repeat (MUL_CYCLES) @(negedge clk);
    @(negedge clk);
    chk1("mulhu_valid", out_valid, 1'b1);
    chk("mulhu_data", out_data, 32'd1);
    step();
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h404, 4'hA);
    repeat (MUL_CYCLES + 1) @(negedge clk);
    chk("mul_data", out_data, 32'hFFFF_FFFE);
    step();
    issue(OP_MUL, 32'd3, 32'd5, 32'd0, 32'h408, 4'hB);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (MUL_CYCLES + 2) begin
      @(negedge clk);
      chk1("mul_flushed", out_valid, 1'b0);
    end
    step();
    issue(OP_MULH, 32'd7, 32'd6, 32'd0, 32'h500, 4'hC);
    step();
`else
    out_ready = 1'b0;
    issue(OP_ADD, 32'd10, 32'd20, 32'd0, 32'h500, 4'hC);
`endif
    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chk1("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_data", out_data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    issue(OP_AUIPC, 32'd0, 32'd0, 32'd1, 32'h1000, 4'hD);
    @(negedge clk);
    chk("auipc_data", out_data, 32'h2000);
    step();

    // randomized traffic with random backpressure and flushes
    rnd_on = 1'b1;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) step();
      issue(6'($urandom_range(0, 40)), pick(), pick(), $urandom, $urandom & 32'hFFFF_FFFC,
            4'($urandom));
    end
    rnd_on = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (MUL_CYCLES + 4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
